// File: rtl/knapsack_search.sv
// rtl/knapsack_search.sv - exhaustive 0-1 knapsack search engine, one subset per cycle
// Optional decision mode (stop at first subset meeting min_value) under `define KNAPSACK_EARLY_EXIT_EN.
module knapsack_search #(
  parameter int N_ITEMS  = 5,
  parameter int WEIGHT_W = 6,
  parameter int VALUE_W  = 6,
  localparam int ADDR_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
  localparam int VSUM_W  = VALUE_W + $clog2(N_ITEMS + 1),
  localparam int WSUM_W  = WEIGHT_W + $clog2(N_ITEMS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                item_wr_en,
  input  logic [ADDR_W-1:0]   item_wr_addr,
  input  logic [WEIGHT_W-1:0] item_wr_weight,
  input  logic [VALUE_W-1:0]  item_wr_value,
  input  logic [WEIGHT_W-1:0] capacity,
  input  logic [VALUE_W-1:0]  min_value,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N_ITEMS-1:0]  best_mask,
  output logic [VSUM_W-1:0]   best_value,
  output logic [WSUM_W-1:0]   best_weight,
  output logic                feasible
);

`ifdef KNAPSACK_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [WEIGHT_W-1:0] item_w [N_ITEMS];
  logic [VALUE_W-1:0]  item_v [N_ITEMS];

  // Extra top bit marks "all subsets issued"
  logic [N_ITEMS:0]    cnt;
  logic [WEIGHT_W-1:0] cap_r;
  logic [VALUE_W-1:0]  min_r;

  logic                s1_valid;
  logic                s1_last;
  logic [N_ITEMS-1:0]  s1_mask;
  logic [WSUM_W-1:0]   s1_w;
  logic [VSUM_W-1:0]   s1_v;

  logic [WSUM_W-1:0]   sum_w;
  logic [VSUM_W-1:0]   sum_v;

  logic accept, issue, eval, qualifies, better, hit;

  assign accept    = (state == IDLE) && start;
  assign issue     = (state == SEARCH) && !cnt[N_ITEMS];
  assign eval      = (state == SEARCH) && s1_valid;
  assign qualifies = s1_w <= WSUM_W'(cap_r);
  assign better    = (s1_v > best_value) || ((s1_v == best_value) && (s1_w < best_weight));
  assign hit       = EARLY_EXIT && eval && qualifies && (s1_v >= VSUM_W'(min_r));

  assign busy = (state == SEARCH) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    sum_w = '0;
    sum_v = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (cnt[i]) begin
        sum_w = sum_w + WSUM_W'(item_w[i]);
        sum_v = sum_v + VSUM_W'(item_v[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (hit || (eval && s1_last)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        item_w[i] <= '0;
        item_v[i] <= '0;
      end
    end else if (item_wr_en && (state == IDLE) && (int'(item_wr_addr) < N_ITEMS)) begin
      item_w[item_wr_addr] <= item_wr_weight;
      item_v[item_wr_addr] <= item_wr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cap_r       <= '0;
      min_r       <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_mask     <= '0;
      s1_w        <= '0;
      s1_v        <= '0;
      best_mask   <= '0;
      best_value  <= '0;
      best_weight <= '0;
      feasible    <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (accept) begin
        cnt         <= '0;
        cap_r       <= capacity;
        min_r       <= min_value;
        best_mask   <= '0;
        best_value  <= '0;
        best_weight <= '0;
        feasible    <= 1'b0;
      end else if (issue) begin
        cnt <= cnt + 1'b1;
      end
      if (issue) begin
        s1_mask <= cnt[N_ITEMS-1:0];
        s1_w    <= sum_w;
        s1_v    <= sum_v;
        s1_last <= &cnt[N_ITEMS-1:0];
      end
      // Strict compare keeps the earlier (lower) mask on a full tie
      if (hit || (eval && qualifies && better)) begin
        best_mask   <= s1_mask;
        best_value  <= s1_v;
        best_weight <= s1_w;
      end
      if (state == DRAIN) feasible <= best_value >= VSUM_W'(min_r);
    end
  end

endmodule

// File: tb/tb_knapsack_search.sv
// tb/tb_knapsack_search.sv - self-checking bench for knapsack_search against a subset-enumeration model
module tb_knapsack_search;
  localparam int N  = 5;
  localparam int WW = 6;
  localparam int VW = 6;
  localparam int AW = 3;
  localparam int VS = 9;
  localparam int WS = 9;

  logic          clk;
  logic          rst_n;
  logic          item_wr_en;
  logic [AW-1:0] item_wr_addr;
  logic [WW-1:0] item_wr_weight;
  logic [VW-1:0] item_wr_value;
  logic [WW-1:0] capacity;
  logic [VW-1:0] min_value;
  logic          start;
  logic          busy;
  logic          done;
  logic [N-1:0]  best_mask;
  logic [VS-1:0] best_value;
  logic [WS-1:0] best_weight;
  logic          feasible;

  int compared;
  int mismatched;
  int tw [N];
  int tv [N];

  knapsack_search #(.N_ITEMS(N), .WEIGHT_W(WW), .VALUE_W(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .item_wr_en(item_wr_en), .item_wr_addr(item_wr_addr),
    .item_wr_weight(item_wr_weight), .item_wr_value(item_wr_value),
    .capacity(capacity), .min_value(min_value), .start(start),
    .busy(busy), .done(done), .best_mask(best_mask),
    .best_value(best_value), .best_weight(best_weight), .feasible(feasible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void subset_sums(input int mask, output int sw, output int sv);
    sw = 0;
    sv = 0;
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        sw += tw[i];
        sv += tv[i];
      end
  endfunction

  // Optimum: highest value, then lightest, then lowest mask; decision mode takes first hit
  function automatic void model(input int cap, input int mn, output int m, output int v,
                                output int w, output int f, output int de);
    int sw, sv;
    v = 0;
    for (int s = 0; s < (1 << N); s++) begin
      subset_sums(s, sw, sv);
      if (sw <= cap && sv > v) v = sv;
    end
    w = 1 << 30;
    for (int s = 0; s < (1 << N); s++) begin
      subset_sums(s, sw, sv);
      if (sw <= cap && sv == v && sw < w) w = sw;
    end
    m = 0;
    for (int s = (1 << N) - 1; s >= 0; s--) begin
      subset_sums(s, sw, sv);
      if (sw <= cap && sv == v && sw == w) m = s;
    end
    f  = (v >= mn) ? 1 : 0;
    de = (1 << N) + 2;
`ifdef KNAPSACK_EARLY_EXIT_EN
    for (int s = 0; s < (1 << N); s++) begin
      subset_sums(s, sw, sv);
      if (sw <= cap && sv >= mn) begin
        m = s; v = sv; w = sw; f = 1; de = s + 3;
        break;
      end
    end
`endif
  endfunction

  task automatic write_item(input int a, input int w, input int v);
    @(negedge clk);
    item_wr_en     = 1'b1;
    item_wr_addr   = AW'(a);
    item_wr_weight = WW'(w);
    item_wr_value  = VW'(v);
    @(posedge clk);
    #1 item_wr_en = 1'b0;
    if (a < N) begin
      tw[a] = w;
      tv[a] = v;
    end
  endtask

  task automatic run_search(input int cap, input int mn, input string tag, input bit disturb,
                            input bit wr, input int wi, input int ww, input int wv);
    int m, v, w, f, de, got;
    @(negedge clk);
    capacity  = WW'(cap);
    min_value = VW'(mn);
    start     = 1'b1;
    if (wr) begin
      item_wr_en     = 1'b1;
      item_wr_addr   = AW'(wi);
      item_wr_weight = WW'(ww);
      item_wr_value  = VW'(wv);
      if (wi < N) begin
        tw[wi] = ww;
        tv[wi] = wv;
      end
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    item_wr_en = 1'b0;
    model(cap, mn, m, v, w, f, de);
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check({tag, "_busy_early"}, 32'(busy), 1);
      if (disturb && k == 3) begin
        start          = 1'b1;
        item_wr_en     = 1'b1;
        item_wr_addr   = 3'd0;
        item_wr_weight = 6'd1;
        item_wr_value  = 6'd63;
      end
      if (disturb && k == 4) begin
        start      = 1'b0;
        item_wr_en = 1'b0;
      end
      if (done) begin
        got = k;
        break;
      end
    end
    start      = 1'b0;
    item_wr_en = 1'b0;
    check({tag, "_done_edge"}, got, de);
    check({tag, "_mask"}, 32'(best_mask), m);
    check({tag, "_value"}, 32'(best_value), v);
    check({tag, "_weight"}, 32'(best_weight), w);
    check({tag, "_feasible"}, 32'(feasible), f);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_mask_hold"}, 32'(best_mask), m);
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    item_wr_en     = 1'b0;
    item_wr_addr   = '0;
    item_wr_weight = '0;
    item_wr_value  = '0;
    capacity       = '0;
    min_value      = '0;
    start          = 1'b0;
    for (int i = 0; i < N; i++) begin
      tw[i] = 0;
      tv[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_feasible", 32'(feasible), 0);
    check("rst_mask", 32'(best_mask), 0);
    check("rst_value", 32'(best_value), 0);
    check("rst_weight", 32'(best_weight), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check("idle_no_done", 32'(done), 0);
    end

    write_item(0, 12, 4);
    write_item(1, 1, 2);
    write_item(2, 2, 2);
    write_item(3, 1, 1);
    write_item(4, 4, 10);
    run_search(15, 15, "ex_min15", 1'b0, 1'b0, 0, 0, 0);
    run_search(15, 16, "ex_min16", 1'b1, 1'b0, 0, 0, 0);
    run_search(15, 12, "ex_min12", 1'b0, 1'b0, 0, 0, 0);

    write_item(5, 1, 63);
    write_item(7, 0, 63);
    run_search(15, 15, "oob_write", 1'b0, 1'b0, 0, 0, 0);
    run_search(0, 0, "cap0", 1'b0, 1'b0, 0, 0, 0);

    write_item(0, 3, 5);
    write_item(1, 2, 5);
    write_item(2, 15, 0);
    write_item(3, 15, 0);
    write_item(4, 15, 0);
    run_search(3, 5, "tie", 1'b0, 1'b0, 0, 0, 0);
    run_search(3, 5, "wr_with_start", 1'b0, 1'b1, 3, 1, 7);

    @(negedge clk);
    capacity  = 6'd15;
    min_value = 6'd15;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_mask", 32'(best_mask), 0);
    check("midrst_value", 32'(best_value), 0);
    check("midrst_weight", 32'(best_weight), 0);
    check("midrst_feasible", 32'(feasible), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      tw[i] = 0;
      tv[i] = 0;
    end
    run_search(20, 0, "post_rst", 1'b0, 1'b0, 0, 0, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        write_item(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      run_search(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), $sformatf("rnd%0d", it),
                 1'b0, it[0], int'($urandom_range(0, 4)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
